// File: rtl/npu_pkg.sv
// Shared opcodes, status codes and FSM encoding for the NPU stream sequencer.
package npu_pkg;

    localparam logic [7:0] OP_SET_BIAS = 8'hA5;
    localparam logic [7:0] OP_RUN      = 8'h5A;

    localparam logic [7:0] ST_CLEAN    = 8'h00;
    localparam logic [7:0] ST_OVERRUN  = 8'h01;
    localparam logic [7:0] ST_TIMEOUT  = 8'h02;

    localparam logic signed [15:0] BIAS_RESET = -16'sd25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS_LO,
        S_BIAS_HI,
        S_LEN,
        S_W_LO,
        S_W_HI,
        S_DRAIN,
        S_STATUS
    } state_e;

    function automatic logic [7:0] status_code(input logic timed_out, input logic overran);
        return (timed_out ? ST_TIMEOUT : ST_CLEAN) | (overran ? ST_OVERRUN : ST_CLEAN);
    endfunction

endpackage

// File: rtl/npu_result_fifo.sv
// Byte FIFO for engine results and status bytes; head entry is readable combinationally.
module npu_result_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [7:0]               wdata_i,
    input  logic                     pop_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   free_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign count   = wr_ptr_q - rd_ptr_q;
    assign free_o  = (AW+1)'(DEPTH) - count;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/npu_stream_sequencer.sv
// Frames UART bytes into bias updates and weight runs, feeds the compute engine,
// and streams results plus one status byte per run back out over UART TX.
module npu_stream_sequencer #(
    parameter int          FIFO_DEPTH     = 8,
    parameter int          TIMEOUT_CYCLES = 270000,
    parameter logic [15:0] BIAS_RESET     = npu_pkg::BIAS_RESET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_tick,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        cmp_valid,
    input  logic        cmp_ready,
    output logic [15:0] cmp_word,
    output logic [15:0] cmp_bias,
    input  logic        res_valid,
    input  logic [7:0]  res_byte,
    output logic        frame_active,
    output logic        overrun,
    output logic        timeout_err,
    output logic [15:0] weight_count
);
    import npu_pkg::*;

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]     FREE_NEED = (AW+1)'(2);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q;
    logic [7:0]    bias_lo_q, lo_q, tx_data_q;
    logic [15:0]   cmp_bias_q, pend_q, weight_count_q;
    logic [8:0]    remaining_q;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          pend_full_q, outstanding_q, overrun_q, timeout_err_q;
    logic          frame_active_q, frame_tmo_q, tx_start_q, tx_start_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty, status_push;
    logic [7:0]    fifo_wdata, fifo_rdata;
    logic [AW:0]   fifo_free;
    logic          xfer, hi_tick, tmo_run, tmo_fire;

    npu_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .free_o  (fifo_free)
    );

    // One FIFO slot stays reserved so the status byte always fits after the last result.
    assign cmp_valid   = pend_full_q && !outstanding_q && (fifo_free >= FREE_NEED);
    assign xfer        = cmp_valid && cmp_ready;
    assign hi_tick     = (state_q == S_W_HI) && rx_tick;

    assign status_push = (state_q == S_STATUS) && !res_valid && !fifo_full;
    assign fifo_push   = res_valid || status_push;
    assign fifo_wdata  = res_valid ? res_byte : status_code(frame_tmo_q, overrun_q);

    // The one-cycle guard covers the latency before tx_busy rises.
    assign tx_start_d  = !fifo_empty && !tx_busy && !tx_start_q;
    assign fifo_pop    = tx_start_d;

    assign tmo_run  = state_q inside {S_BIAS_LO, S_BIAS_HI, S_LEN, S_W_LO, S_W_HI};
    assign tmo_fire = tmo_run && !rx_tick && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        // NOTE: default assignment first so no path leaves tmo_cnt_d unassigned (no latch).
        tmo_cnt_d = '0;
        if (tmo_run && !rx_tick && !tmo_fire) tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            bias_lo_q      <= '0;
            lo_q           <= '0;
            tx_data_q      <= '0;
            cmp_bias_q     <= BIAS_RESET;
            pend_q         <= '0;
            weight_count_q <= '0;
            remaining_q    <= '0;
            tmo_cnt_q      <= '0;
            pend_full_q    <= 1'b0;
            outstanding_q  <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            frame_active_q <= 1'b0;
            frame_tmo_q    <= 1'b0;
            tx_start_q     <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tx_start_q <= tx_start_d;
            if (tx_start_d) tx_data_q <= fifo_rdata;

            if (xfer) begin
                outstanding_q  <= 1'b1;
                weight_count_q <= weight_count_q + 1'b1;
            end else if (res_valid) begin
                outstanding_q  <= 1'b0;
            end

            // A word leaving this cycle frees the pending slot for the arriving one.
            if (hi_tick && (!pend_full_q || xfer)) begin
                pend_q      <= {rx_byte, lo_q};
                pend_full_q <= 1'b1;
            end else begin
                if (hi_tick)         overrun_q   <= 1'b1;
                if (xfer || tmo_fire) pend_full_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: if (rx_tick) begin
                    if (rx_byte == OP_SET_BIAS) begin
                        state_q        <= S_BIAS_LO;
                        frame_active_q <= 1'b1;
                    end else if (rx_byte == OP_RUN) begin
                        state_q        <= S_LEN;
                        frame_active_q <= 1'b1;
                        overrun_q      <= 1'b0;
                        frame_tmo_q    <= 1'b0;
                    end
                end
                S_BIAS_LO: if (rx_tick) begin
                    bias_lo_q <= rx_byte;
                    state_q   <= S_BIAS_HI;
                end
                S_BIAS_HI: if (rx_tick) begin
                    cmp_bias_q     <= {rx_byte, bias_lo_q};
                    frame_active_q <= 1'b0;
                    state_q        <= S_IDLE;
                end
                S_LEN: if (rx_tick) begin
                    remaining_q <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                    state_q     <= S_W_LO;
                end
                S_W_LO: if (rx_tick) begin
                    lo_q    <= rx_byte;
                    state_q <= S_W_HI;
                end
                S_W_HI: if (rx_tick) begin
                    remaining_q <= remaining_q - 1'b1;
                    state_q     <= (remaining_q == 9'd1) ? S_DRAIN : S_W_LO;
                end
                S_DRAIN: if (!pend_full_q && !outstanding_q && !res_valid) state_q <= S_STATUS;
                S_STATUS: if (status_push) begin
                    frame_active_q <= 1'b0;
                    state_q        <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (tmo_fire) begin
                timeout_err_q <= 1'b1;
                frame_tmo_q   <= 1'b1;
                state_q       <= S_DRAIN;
            end
        end
    end

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign cmp_word     = pend_q;
    assign cmp_bias     = cmp_bias_q;
    assign frame_active = frame_active_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;
    assign weight_count = weight_count_q;

endmodule

// File: tb/tb_npu_stream_sequencer.sv
// Directed bench for npu_stream_sequencer with a UART TX model and a simple
// ReLU/shift compute-engine model; expected bytes are hand-computed per scenario.
module tb_npu_stream_sequencer;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = '0;
    logic        rx_tick = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        cmp_valid;
    logic        cmp_ready = 1'b1;
    logic [15:0] cmp_word;
    logic [15:0] cmp_bias;
    logic        res_valid = 1'b0;
    logic [7:0]  res_byte = '0;
    logic        frame_active;
    logic        overrun;
    logic        timeout_err;
    logic [15:0] weight_count;

    always #5 clk = ~clk;

    npu_stream_sequencer #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_tick      (rx_tick),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .cmp_valid    (cmp_valid),
        .cmp_ready    (cmp_ready),
        .cmp_word     (cmp_word),
        .cmp_bias     (cmp_bias),
        .res_valid    (res_valid),
        .res_byte     (res_byte),
        .frame_active (frame_active),
        .overrun      (overrun),
        .timeout_err  (timeout_err),
        .weight_count (weight_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    logic [7:0]  txq[$];
    logic [15:0] accq[$];
    logic [15:0] acc_bias = '0;
    logic        hold_busy = 1'b0;
    logic        ready_en = 1'b1;
    int          busy_cnt = 0;
    int          last_tx = -100;
    int          eng_cnt = 0;
    logic [7:0]  eng_res = '0;

    always @(posedge clk) cyc++;

    // UART TX: busy for four cycles after each start pulse, or while held.
    always @(negedge clk) begin
        if (tx_start) begin
            check("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
            check("tx_pulse_gap_ge2", {31'd0, (cyc - last_tx) >= 2}, 32'd1);
            last_tx = cyc;
            txq.push_back(tx_data);
            busy_cnt = 4;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = hold_busy || (busy_cnt > 0);
    end

    function automatic logic [7:0] engine_fn(input logic [15:0] w);
        return w[15] ? 8'h00 : w[15:8];
    endfunction

    // Compute engine: result strobe two negedges after the accepting edge.
    always @(negedge clk) begin
        res_valid = 1'b0;
        cmp_ready = ready_en;
        if (rst) begin
            eng_cnt = 0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    res_valid = 1'b1;
                    res_byte  = eng_res;
                end
            end
            if (cmp_valid && cmp_ready) begin
                eng_res  = engine_fn(cmp_word);
                eng_cnt  = 2;
                accq.push_back(cmp_word);
                acc_bias = cmp_bias;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_tick = 1'b1;
        tick(1);
        rx_tick = 1'b0;
        tick(2);
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int k = 0;
        while (txq.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        tick(8);
        check(tag, txq.size(), n);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_tx_start"},     {31'd0, tx_start},     32'd0);
        check({pfx, "_tx_data"},      {24'd0, tx_data},      32'd0);
        check({pfx, "_cmp_valid"},    {31'd0, cmp_valid},    32'd0);
        check({pfx, "_cmp_word"},     {16'd0, cmp_word},     32'd0);
        check({pfx, "_cmp_bias"},     {16'd0, cmp_bias},     32'h0000FFE7);
        check({pfx, "_frame_active"}, {31'd0, frame_active}, 32'd0);
        check({pfx, "_overrun"},      {31'd0, overrun},      32'd0);
        check({pfx, "_timeout_err"},  {31'd0, timeout_err},  32'd0);
        check({pfx, "_weight_count"}, {16'd0, weight_count}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;

        // Reset, then RUN N=2: results 0x01, 0x00, status 0x00.
        rst = 1'b1;
        tick(3);
        check_reset("rst0");
        rst = 1'b0;
        tick(2);
        txq.delete(); accq.delete();
        send_byte(8'h5A);
        check("t1_frame_active_on", {31'd0, frame_active}, 32'd1);
        send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hF0); send_byte(8'hFF);
        wait_tx(3, 200, "t1_tx_count");
        check("t1_tx0", {24'd0, txq[0]}, 32'h01);
        check("t1_tx1", {24'd0, txq[1]}, 32'h00);
        check("t1_tx2", {24'd0, txq[2]}, 32'h00);
        check("t1_acc0", {16'd0, accq[0]}, 32'h0100);
        check("t1_acc1", {16'd0, accq[1]}, 32'hFFF0);
        check("t1_weight_count", {16'd0, weight_count}, 32'd2);
        check("t1_frame_active_off", {31'd0, frame_active}, 32'd0);

        // SET_BIAS twice; no reply bytes; next weight carries the new bias.
        txq.delete(); accq.delete();
        send_byte(8'hA5); send_byte(8'hE7); send_byte(8'hFF);
        check("t2_bias_ffe7", {16'd0, cmp_bias}, 32'hFFE7);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
        check("t2_bias_0010", {16'd0, cmp_bias}, 32'h0010);
        tick(20);
        check("t2_no_tx", txq.size(), 0);
        send_byte(8'h5A); send_byte(8'h01);
        send_byte(8'h05); send_byte(8'h00);
        wait_tx(2, 200, "t2_tx_count");
        check("t2_acc_word", {16'd0, accq[0]}, 32'h0005);
        check("t2_acc_bias", {16'd0, acc_bias}, 32'h0010);
        check("t2_tx0", {24'd0, txq[0]}, 32'h00);
        check("t2_tx1", {24'd0, txq[1]}, 32'h00);

        // Engine not ready during RUN N=3: two words dropped, status 0x01.
        txq.delete(); accq.delete();
        ready_en = 1'b0;
        send_byte(8'h5A); send_byte(8'h03);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h00); send_byte(8'h04);
        tick(4);
        check("t3_overrun", {31'd0, overrun}, 32'd1);
        check("t3_cmp_valid", {31'd0, cmp_valid}, 32'd1);
        check("t3_cmp_word", {16'd0, cmp_word}, 32'h0200);
        check("t3_frame_active", {31'd0, frame_active}, 32'd1);
        ready_en = 1'b1;
        wait_tx(2, 200, "t3_tx_count");
        check("t3_tx0", {24'd0, txq[0]}, 32'h02);
        check("t3_tx1", {24'd0, txq[1]}, 32'h01);
        check("t3_acc_count", accq.size(), 1);
        check("t3_weight_count", {16'd0, weight_count}, 32'd4);
        check("t3_overrun_sticky", {31'd0, overrun}, 32'd1);

        // TX held busy: seven results fill all but the status slot, eighth word waits.
        txq.delete(); accq.delete();
        hold_busy = 1'b1;
        tick(2);
        send_byte(8'h5A); send_byte(8'd20);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'h00);
            send_byte(i[7:0]);
        end
        tick(10);
        check("t4_stall_cmp_valid", {31'd0, cmp_valid}, 32'd0);
        check("t4_stall_cmp_word", {16'd0, cmp_word}, 32'h0800);
        check("t4_stall_weight_count", {16'd0, weight_count}, 32'd11);
        check("t4_stall_no_tx", txq.size(), 0);
        hold_busy = 1'b0;
        tick(30);
        for (int i = 9; i <= 20; i++) begin
            send_byte(8'h00);
            send_byte(i[7:0]);
        end
        wait_tx(21, 2000, "t4_tx_count");
        for (int i = 0; i < 20; i++) check($sformatf("t4_tx%0d", i), {24'd0, txq[i]}, i + 1);
        check("t4_tx_status", {24'd0, txq[20]}, 32'h00);
        check("t4_weight_count", {16'd0, weight_count}, 32'd24);
        check("t4_no_overrun", {31'd0, overrun}, 32'd0);

        // RUN N=4 abandoned after three bytes: one result then status 0x02.
        txq.delete(); accq.delete();
        send_byte(8'h5A); send_byte(8'h04);
        send_byte(8'h00); send_byte(8'h06); send_byte(8'h00);
        check("t5_no_early_timeout", {31'd0, timeout_err}, 32'd0);
        k = 0;
        while (!timeout_err && k < 3 * TMO) begin
            tick(1);
            k++;
        end
        check("t5_timeout_err", {31'd0, timeout_err}, 32'd1);
        wait_tx(2, 200, "t5_tx_count");
        check("t5_tx0", {24'd0, txq[0]}, 32'h06);
        check("t5_tx1", {24'd0, txq[1]}, 32'h02);
        check("t5_frame_active_off", {31'd0, frame_active}, 32'd0);
        send_byte(8'hA5); send_byte(8'h34); send_byte(8'h12);
        check("t5_idle_accepts_bias", {16'd0, cmp_bias}, 32'h1234);
        check("t5_timeout_sticky", {31'd0, timeout_err}, 32'd1);
        check("t5_weight_count", {16'd0, weight_count}, 32'd25);

        // Reset mid-RUN with results queued: everything discarded, next RUN is clean.
        txq.delete(); accq.delete();
        hold_busy = 1'b1;
        tick(2);
        send_byte(8'h5A); send_byte(8'h03);
        send_byte(8'h00); send_byte(8'h07);
        send_byte(8'h00); send_byte(8'h08);
        tick(6);
        rst = 1'b1;
        tick(1);
        check_reset("t6");
        rst = 1'b0;
        hold_busy = 1'b0;
        txq.delete();
        tick(40);
        check("t6_no_tx_after_reset", txq.size(), 0);
        send_byte(8'h5A); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h03);
        wait_tx(2, 200, "t6_tx_count");
        check("t6_tx0", {24'd0, txq[0]}, 32'h03);
        check("t6_tx1", {24'd0, txq[1]}, 32'h00);
        check("t6_weight_count", {16'd0, weight_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
